// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register with ADD/SUB result saturation, condition flags
// and a saturating count of how many results were clamped.
module ex_mem_flag_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [3:0]  ex_op,
  input  logic [15:0] ex_sum,
  input  logic        ex_ovfl,
  input  logic        ex_wr_reg,
  input  logic [3:0]  ex_rd,
  output logic        mem_valid,
  output logic [15:0] mem_result,
  output logic        mem_wr_reg,
  output logic [3:0]  mem_rd,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_n,
  output logic [7:0]  sat_cnt
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;

  logic        mem_valid_reg;
  logic [15:0] mem_result_reg;
  logic        mem_wr_reg_reg;
  logic [3:0]  mem_rd_reg;
  logic        flag_z_reg;
  logic        flag_v_reg;
  logic        flag_n_reg;
  logic [7:0]  sat_cnt_reg;

  logic        advance;
  logic        is_addsub;
  logic        is_xor;
  logic        sat_hit;
  logic [15:0] sat_result_next;

  // Decode the instruction in EX and clamp overflowing ADD/SUB results.
  // A set sign bit on an overflowed sum means two positives wrapped negative.
  always_comb begin
    is_addsub = (ex_op == OP_ADD) || (ex_op == OP_SUB);
    is_xor    = (ex_op == OP_XOR);
    advance   = ex_valid & ~stall & ~flush & ~rst;
    sat_hit   = is_addsub & ex_ovfl;
    sat_result_next = ex_sum;
    if (sat_hit) begin
      sat_result_next = ex_sum[15] ? 16'h7FFF : 16'h8000;
    end
  end

  // MEM-stage register: load on advance, bubble on flush or empty EX,
  // otherwise hold. Flush wins over stall; result and rd are kept in bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid_reg  <= 1'b0;
      mem_result_reg <= 16'h0000;
      mem_wr_reg_reg <= 1'b0;
      mem_rd_reg     <= 4'h0;
    end else if (advance) begin
      mem_valid_reg  <= 1'b1;
      mem_result_reg <= sat_result_next;
      mem_wr_reg_reg <= ex_wr_reg;
      mem_rd_reg     <= ex_rd;
    end else if (~stall | flush) begin
      mem_valid_reg  <= 1'b0;
      mem_wr_reg_reg <= 1'b0;
    end
  end

  // Condition flags: full update from ADD/SUB, zero-only update from XOR,
  // hold for every other opcode and every cycle that does not advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z_reg <= 1'b0;
      flag_v_reg <= 1'b0;
      flag_n_reg <= 1'b0;
    end else if (advance && is_addsub) begin
      flag_z_reg <= (sat_result_next == 16'h0000);
      flag_v_reg <= ex_ovfl;
      flag_n_reg <= sat_result_next[15];
    end else if (advance && is_xor) begin
      flag_z_reg <= (ex_sum == 16'h0000);
    end
  end

  // Count clamped results; the counter sticks at its maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt_reg <= 8'h00;
    end else if (advance && sat_hit && (sat_cnt_reg != 8'hFF)) begin
      sat_cnt_reg <= sat_cnt_reg + 8'd1;
    end
  end

  assign mem_valid  = mem_valid_reg;
  assign mem_result = mem_result_reg;
  assign mem_wr_reg = mem_wr_reg_reg;
  assign mem_rd     = mem_rd_reg;
  assign flag_z     = flag_z_reg;
  assign flag_v     = flag_v_reg;
  assign flag_n     = flag_n_reg;
  assign sat_cnt    = sat_cnt_reg;

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Bench for ex_mem_flag_stage: hand-derived vector table, a 300-overflow
// counter sequence with reset, then randomized traffic against a model.
module tb_ex_mem_flag_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic [3:0]  ex_op = 4'h0;
  logic [15:0] ex_sum = 16'h0000;
  logic        ex_ovfl = 1'b0;
  logic        ex_wr_reg = 1'b0;
  logic [3:0]  ex_rd = 4'h0;
  logic        mem_valid;
  logic [15:0] mem_result;
  logic        mem_wr_reg;
  logic [3:0]  mem_rd;
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;
  logic [7:0]  sat_cnt;

  int checks = 0;
  int passes = 0;

  ex_mem_flag_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .ex_valid   (ex_valid),
    .ex_op      (ex_op),
    .ex_sum     (ex_sum),
    .ex_ovfl    (ex_ovfl),
    .ex_wr_reg  (ex_wr_reg),
    .ex_rd      (ex_rd),
    .mem_valid  (mem_valid),
    .mem_result (mem_result),
    .mem_wr_reg (mem_wr_reg),
    .mem_rd     (mem_rd),
    .flag_z     (flag_z),
    .flag_v     (flag_v),
    .flag_n     (flag_n),
    .sat_cnt    (sat_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state (what the MEM stage should show after each edge).
  logic        m_valid, m_wr, m_z, m_v, m_n;
  logic [15:0] m_res;
  logic [3:0]  m_rd;
  int          m_cnt;

  // Apply the behavioural rules to one clock edge using the current inputs.
  task automatic model_edge();
    bit arith, go;
    logic [15:0] clamped;
    if (rst) begin
      m_valid = 0; m_wr = 0; m_res = 0; m_rd = 0;
      m_z = 0; m_v = 0; m_n = 0; m_cnt = 0;
      return;
    end
    arith = (ex_op == 4'd0) || (ex_op == 4'd1);
    go = ex_valid && !stall && !flush;
    if (arith && ex_ovfl)
      clamped = ex_sum[15] ? 16'h7FFF : 16'h8000;
    else
      clamped = ex_sum;
    if (go) begin
      m_valid = 1; m_res = clamped; m_wr = ex_wr_reg; m_rd = ex_rd;
      if (arith) begin
        m_n = clamped[15];
        m_z = (clamped == 16'h0000);
        m_v = ex_ovfl;
        if (ex_ovfl) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      end else if (ex_op == 4'd2) begin
        m_z = (ex_sum == 16'h0000);
      end
    end else if (flush || !stall) begin
      m_valid = 0; m_wr = 0;
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step(input logic r, input logic s, input logic f, input logic v,
                      input logic [3:0] op, input logic [15:0] sum, input logic ov,
                      input logic wr, input logic [3:0] rd);
    rst = r; stall = s; flush = f; ex_valid = v;
    ex_op = op; ex_sum = sum; ex_ovfl = ov; ex_wr_reg = wr; ex_rd = rd;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".mem_valid"},  16'(mem_valid),  16'(m_valid));
    chk({tag, ".mem_result"}, mem_result,      m_res);
    chk({tag, ".mem_wr_reg"}, 16'(mem_wr_reg), 16'(m_wr));
    chk({tag, ".mem_rd"},     16'(mem_rd),     16'(m_rd));
    chk({tag, ".flag_z"},     16'(flag_z),     16'(m_z));
    chk({tag, ".flag_v"},     16'(flag_v),     16'(m_v));
    chk({tag, ".flag_n"},     16'(flag_n),     16'(m_n));
    chk({tag, ".sat_cnt"},    16'(sat_cnt),    16'(m_cnt));
  endtask

  typedef struct {
    logic        rst, stall, flush, valid;
    logic [3:0]  op;
    logic [15:0] sum;
    logic        ovfl, wr;
    logic [3:0]  rd;
    logic        e_valid;
    logic [15:0] e_res;
    logic        e_wr;
    logic [3:0]  e_rd;
    logic        e_z, e_v, e_n;
    logic [7:0]  e_cnt;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl [NVEC];

  initial begin
    // rst stall flush valid op sum ovfl wr rd | valid res wr rd z v n cnt
    tbl[0]  = '{1,0,0,0, 4'h0, 16'h0000, 0,0, 4'h0,  0, 16'h0000, 0, 4'h0, 0,0,0, 8'h00}; // reset
    tbl[1]  = '{0,0,0,1, 4'h0, 16'h8001, 1,1, 4'h3,  1, 16'h7FFF, 1, 4'h3, 0,1,0, 8'h01}; // ADD +ovfl
    tbl[2]  = '{0,0,0,1, 4'h1, 16'h0000, 0,1, 4'h5,  1, 16'h0000, 1, 4'h5, 1,0,0, 8'h01}; // SUB zero
    tbl[3]  = '{0,0,0,1, 4'h0, 16'hFFFF, 0,0, 4'h2,  1, 16'hFFFF, 0, 4'h2, 0,0,1, 8'h01}; // ADD neg
    tbl[4]  = '{0,0,0,1, 4'h2, 16'h0000, 0,1, 4'h7,  1, 16'h0000, 1, 4'h7, 1,0,1, 8'h01}; // XOR zero
    tbl[5]  = '{0,1,0,1, 4'h0, 16'h1234, 0,1, 4'h4,  1, 16'h0000, 1, 4'h7, 1,0,1, 8'h01}; // stall 1
    tbl[6]  = '{0,1,0,1, 4'h0, 16'h1234, 0,1, 4'h4,  1, 16'h0000, 1, 4'h7, 1,0,1, 8'h01}; // stall 2
    tbl[7]  = '{0,1,0,1, 4'h0, 16'h1234, 0,1, 4'h4,  1, 16'h0000, 1, 4'h7, 1,0,1, 8'h01}; // stall 3
    tbl[8]  = '{0,0,0,1, 4'h0, 16'h1234, 0,1, 4'h4,  1, 16'h1234, 1, 4'h4, 0,0,0, 8'h01}; // released
    tbl[9]  = '{0,0,1,1, 4'h0, 16'h8001, 1,1, 4'h9,  0, 16'h1234, 0, 4'h4, 0,0,0, 8'h01}; // flush
    tbl[10] = '{0,0,0,1, 4'h1, 16'h7FFE, 1,1, 4'h1,  1, 16'h8000, 1, 4'h1, 0,1,1, 8'h02}; // SUB -ovfl
    tbl[11] = '{0,0,0,0, 4'h0, 16'h8001, 1,1, 4'h8,  0, 16'h8000, 0, 4'h1, 0,1,1, 8'h02}; // empty EX
    tbl[12] = '{0,0,0,1, 4'h3, 16'hABCD, 1,1, 4'h6,  1, 16'hABCD, 1, 4'h6, 0,1,1, 8'h02}; // other op
    tbl[13] = '{0,1,1,1, 4'h0, 16'h8001, 1,1, 4'h9,  0, 16'hABCD, 0, 4'h6, 0,1,1, 8'h02}; // stall+flush
    tbl[14] = '{1,1,1,1, 4'h0, 16'h8001, 1,1, 4'h9,  0, 16'h0000, 0, 4'h0, 0,0,0, 8'h00}; // rst wins
    tbl[15] = '{0,0,0,1, 4'h0, 16'h0005, 0,1, 4'h2,  1, 16'h0005, 1, 4'h2, 0,0,0, 8'h00}; // resume
    tbl[16] = '{0,0,0,1, 4'h2, 16'h0000, 1,0, 4'hA,  1, 16'h0000, 0, 4'hA, 1,0,0, 8'h00}; // XOR ovfl

    for (int i = 0; i < NVEC; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].valid, tbl[i].op,
           tbl[i].sum, tbl[i].ovfl, tbl[i].wr, tbl[i].rd);
      $display("vec %0d: valid=%b res=%h wr=%b rd=%h z=%b v=%b n=%b cnt=%0d",
               i, mem_valid, mem_result, mem_wr_reg, mem_rd, flag_z, flag_v, flag_n, sat_cnt);
      chk({tag, ".mem_valid"},  16'(mem_valid),  16'(tbl[i].e_valid));
      chk({tag, ".mem_result"}, mem_result,      tbl[i].e_res);
      chk({tag, ".mem_wr_reg"}, 16'(mem_wr_reg), 16'(tbl[i].e_wr));
      chk({tag, ".mem_rd"},     16'(mem_rd),     16'(tbl[i].e_rd));
      chk({tag, ".flag_z"},     16'(flag_z),     16'(tbl[i].e_z));
      chk({tag, ".flag_v"},     16'(flag_v),     16'(tbl[i].e_v));
      chk({tag, ".flag_n"},     16'(flag_n),     16'(tbl[i].e_n));
      chk({tag, ".sat_cnt"},    16'(sat_cnt),    16'(tbl[i].e_cnt));
    end

    // 300 back-to-back overflowing ADDs: counter must stick at 255.
    step(1, 0, 0, 0, 4'h0, 16'h0000, 0, 0, 4'h0);
    for (int i = 1; i <= 300; i++) begin
      step(0, 0, 0, 1, 4'h0, 16'h8001, 1, 1, 4'hC);
      if (i == 254 || i == 255 || i == 256 || i == 300)
        $display("ovfl add %0d: sat_cnt=%0d", i, sat_cnt);
      check_model($sformatf("sat%0d", i));
      if (i == 255) chk("sat_cnt_at_255", 16'(sat_cnt), 16'h00FF);
    end
    chk("sat_cnt_after_300", 16'(sat_cnt), 16'h00FF);

    // One-cycle reset clears everything.
    step(1, 0, 0, 1, 4'h0, 16'h8001, 1, 1, 4'hC);
    $display("post-300 reset: valid=%b res=%h cnt=%0d", mem_valid, mem_result, sat_cnt);
    chk("rst.mem_valid",  16'(mem_valid),  16'h0);
    chk("rst.mem_result", mem_result,      16'h0000);
    chk("rst.mem_wr_reg", 16'(mem_wr_reg), 16'h0);
    chk("rst.mem_rd",     16'(mem_rd),     16'h0);
    chk("rst.flags",      16'({flag_z, flag_v, flag_n}), 16'h0);
    chk("rst.sat_cnt",    16'(sat_cnt),    16'h0);

    // Randomized traffic compared against the model.
    for (int i = 0; i < 2000; i++) begin
      logic r, s, f, v, ov, wr;
      logic [3:0] op;
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 99) < 25);
      f  = ($urandom_range(0, 99) < 10);
      v  = ($urandom_range(0, 99) < 80);
      ov = ($urandom_range(0, 99) < 30);
      wr = $urandom_range(0, 1) == 1;
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
      step(r, s, f, v, op, 16'($urandom), ov, wr, 4'($urandom));
      if (i % 250 == 0)
        $display("rand %0d: valid=%b res=%h z=%b v=%b n=%b cnt=%0d",
                 i, mem_valid, mem_result, flag_z, flag_v, flag_n, sat_cnt);
      check_model($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_flag_stage.md
EX_MEM_FLAG_STAGE -- requirements
Module: ex_mem_flag_stage

Interface
REQ-001 SHALL have ports: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: stall  input  1  hold all state this cycle.
REQ-004 SHALL have ports: flush  input  1  discard the EX instruction; insert a bubble.
REQ-005 SHALL have ports: ex_valid  input  1  EX slot holds a real instruction.
REQ-006 SHALL have ports: ex_op  input  4  opcode: 0000 ADD, 0001 SUB, 0010 XOR; all other codes are non-flag-setting.
REQ-007 SHALL have ports: ex_sum  input  16  raw 16-bit adder/ALU result.
REQ-008 SHALL have ports: ex_ovfl  input  1  adder signed-overflow indication.
REQ-009 SHALL have ports: ex_wr_reg  input  1, ex_rd  input  4  register-write enable and destination.
REQ-010 SHALL have ports: mem_valid  output  1, mem_result  output  16, mem_wr_reg  output  1, mem_rd  output  4  registered MEM-stage copy.
REQ-011 SHALL have ports: flag_z, flag_v, flag_n  output  1 each  registered condition flags.
REQ-012 SHALL have ports: sat_cnt  output  8  count of saturated results.

Function
REQ-013 SHALL define "advance" = ex_valid & ~stall & ~flush & ~rst.
REQ-014 SHALL, for ADD/SUB, derive the saturated result as follows:
- ex_ovfl=1 and ex_sum[15]=1 (positive overflow) -> 16'h7FFF.
- ex_ovfl=1 and ex_sum[15]=0 (negative overflow) -> 16'h8000.
- otherwise -> ex_sum.
REQ-015 SHALL pass ex_sum unmodified for all opcodes other than ADD/SUB, whatever the value of ex_ovfl.
REQ-016 SHALL, on advance, load mem_result (saturated), mem_wr_reg, mem_rd, and set mem_valid=1, with 1-cycle latency.
REQ-017 SHALL, when ~stall & (flush | ~ex_valid), set mem_valid=0 and mem_wr_reg=0; mem_result and mem_rd are don't-care but hold.
REQ-018 SHALL, when stall=1 and flush=0, hold all MEM outputs, flags and sat_cnt.
REQ-019 SHALL, when stall=1 and flush=1 together, apply flush: mem_valid and mem_wr_reg clear, flags and sat_cnt hold.
REQ-020 SHALL, on advance with ADD or SUB, update flags as follows:
- flag_n = saturated result[15].
- flag_z = (saturated result == 0).
- flag_v = ex_ovfl.
REQ-021 SHALL, on advance with XOR, update flag_z only, from ex_sum; flag_n and flag_v hold.
REQ-022 SHALL, for any other opcode, and for any non-advance cycle, hold all flags.
REQ-023 SHALL increment sat_cnt by 1 on each advance where ADD/SUB and ex_ovfl=1.
REQ-024 SHALL saturate sat_cnt at 8'hFF; it never wraps to 0.
REQ-025 SHALL produce flags that are visible the cycle after the updating instruction advances; same-cycle bypass is not provided.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set mem_valid=0, mem_wr_reg=0, mem_result=16'h0000, mem_rd=4'h0, flag_z=0, flag_v=0, flag_n=0, sat_cnt=8'h00.
REQ-027 SHALL give rst priority over stall, flush and advance; reset mid-stall or mid-flush yields exactly the REQ-026 values.
REQ-028 SHALL resume normal advance on the first edge with rst=0.

Verification
REQ-029 SHALL cover ADD with ex_sum=16'h8001, ex_ovfl=1, ex_valid=1 -> next cycle:
- mem_result=16'h7FFF, mem_valid=1.
- flag_n=0, flag_z=0, flag_v=1.
- sat_cnt=1.
REQ-030 SHALL cover SUB with ex_sum=16'h0000, ex_ovfl=0 -> flag_z=1, flag_n=0, flag_v=0, mem_result=16'h0000.
REQ-031 SHALL cover ADD ex_sum=16'hFFFF, ex_ovfl=0 (sets N=1), then XOR ex_sum=16'h0000 -> after XOR: flag_z=1, flag_n still 1, flag_v still 0.
REQ-032 SHALL cover a 3-cycle stall=1 during ADD 16'h1234:
- MEM outputs and flags hold throughout.
- after stall drops, mem_result=16'h1234, mem_valid=1.
REQ-033 SHALL cover flush=1 with ex_valid=1 and ADD overflow -> mem_valid=0, mem_wr_reg=0, flags and sat_cnt unchanged.
REQ-034 SHALL cover 300 consecutive overflowing ADDs -> sat_cnt=8'hFF, then rst=1 for one cycle -> all outputs at REQ-026 values.
